shr_pattern_ctrl: RTL

Serializes the parallel control pattern delivered by the vJTAG data register into the external DUT shift-register chain on the DE0 board. Generates the serial clock, data and load strobe at a programmable rate. Triggers come from the JTAG update-DR pulse or a local start key. One trigger can be queued while a transfer is in progress.

---
 rtl/shr_pattern_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/shr_pattern_ctrl.sv
// Serialises a captured parallel pattern into an external shift-register chain.
// Generates shr_clk, shr_data and shr_load, and can queue one further trigger.
module shr_pattern_ctrl #(
  parameter int WIDTH     = 491,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             udr,
  input  logic             start,
  output logic             shr_clk,
  output logic             shr_data,
  output logic             shr_load,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    bit_cnt,
  output logic [2:0]       dbg_state
);

  localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LOAD     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hp_q, hp_d;
  logic             pend_q, pend_d;
  logic             udr_meta_q, udr_sync_q, udr_prev_q, udr_rise_q;
  logic             trig;
  logic             head_bit;

  // udr comes from the tck domain: two flops, then a registered rising-edge detect.
  assign trig     = udr_rise_q | start;
  assign head_bit = (MSB_FIRST != 0) ? shadow_q[WIDTH-1] : shadow_q[0];

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | (trig && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (trig) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shadow_d = pattern_in;
        cnt_d    = CW'(WIDTH);
        state_d  = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (hp_q == '0) state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (hp_q == '0) begin
          shadow_d = (MSB_FIRST != 0) ? (shadow_q << 1) : (shadow_q >> 1);
          cnt_d    = cnt_q - 1'b1;
          state_d  = (cnt_q == CW'(1)) ? S_LOAD : S_SHIFT_LO;
        end
      end
      S_LOAD: begin
        if (hp_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        pend_d  = 1'b0;
        state_d = (pend_q || trig) ? S_CAPTURE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Shared half-period counter restarts on every state entry, so phase follows the trigger.
    if (state_d != state_q) hp_d = HW'(DIV - 1);
    else if (hp_q == '0)    hp_d = '0;
    else                    hp_d = hp_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      cnt_q      <= '0;
      hp_q       <= '0;
      pend_q     <= 1'b0;
      udr_meta_q <= 1'b0;
      udr_sync_q <= 1'b0;
      udr_prev_q <= 1'b0;
      udr_rise_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      pend_q     <= pend_d;
      udr_meta_q <= udr;
      udr_sync_q <= udr_meta_q;
      udr_prev_q <= udr_sync_q;
      udr_rise_q <= udr_sync_q & ~udr_prev_q;
    end
  end

  assign shr_clk   = (state_q == S_SHIFT_HI);
  assign shr_data  = ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI)) & head_bit;
  assign shr_load  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign bit_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule
